// File: rtl/ema_pkg.sv
// Shared definitions for the multichannel exponential-average ADC reader:
// conversion FSM state encoding and the channel-index width helper.
package ema_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S0 = 2'd0;
    localparam logic [STATE_W-1:0] S1 = 2'd1;
    localparam logic [STATE_W-1:0] S2 = 2'd2;

    // Channel index width; a single channel still gets one (constant-zero) bit.
    function automatic int cw_of(input int c);
        return (c <= 2) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/ema_step.sv
// One exponential-average step, alpha = 2^-K:
// f = floor(a*(2^K-1)/2^K) + floor(s/2^K). The sum never exceeds 2^N-1.
module ema_step #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] s,
    output logic [N-1:0] f
);

    logic [N+K-1:0] p;

    // a*(2^K-1) as a*2^K - a, kept at full N+K width so nothing is lost
    assign p = {a, {K{1'b0}}} - {{K{1'b0}}, a};
    assign f = p[N+K-1:K] + (s >> K);

endmodule

// File: rtl/ema_multicanale.sv
// Round-robin soc/eoc ADC reader keeping one exponential moving average per channel.
// Optional EMA_SEED_EN: a channel's first sample after reset seeds its average directly.
module ema_multicanale
    import ema_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2,
    parameter int C = 4,
    localparam int CW = cw_of(C)
) (
    input  logic          clock,
    input  logic          reset_,
    output logic          soc,
    input  logic          eoc,
    input  logic [N-1:0]  x,
    output logic [CW-1:0] ch,
    output logic [N-1:0]  m,
    output logic [CW-1:0] mch,
    output logic          z
);

    logic [STATE_W-1:0]  state;
    logic [N-1:0]        xs;
    logic [C-1:0][N-1:0] avg;
    logic [N-1:0]        a_cur;
    logic [N-1:0]        f_out;
    logic [N-1:0]        upd;

    // Loop-based select keeps C=1 and non-power-of-two C free of out-of-range indexing
    always_comb begin
        a_cur = '0;
        for (int i = 0; i < C; i++)
            if (ch == CW'(i)) a_cur = avg[i];
    end

    ema_step #(.N(N), .K(K)) u_step (
        .a (a_cur),
        .s (xs),
        .f (f_out)
    );

`ifdef EMA_SEED_EN
    logic [C-1:0] seeded;
    logic         seed_cur;

    always_comb begin
        seed_cur = 1'b0;
        for (int i = 0; i < C; i++)
            if (ch == CW'(i)) seed_cur = seeded[i];
        upd = seed_cur ? f_out : xs;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            seeded <= '0;
        end else if (state == S2) begin
            for (int i = 0; i < C; i++)
                if (ch == CW'(i)) seeded[i] <= 1'b1;
        end
    end
`else
    always_comb begin
        upd = f_out;
    end
`endif

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= S0;
            soc   <= 1'b0;
            z     <= 1'b0;
            m     <= '0;
            mch   <= '0;
            ch    <= '0;
            xs    <= '0;
            avg   <= '0;
        end else begin
            case (state)
                S0: begin
                    z   <= 1'b0;
                    soc <= 1'b1;
                    if (!eoc) state <= S1;
                end
                S1: begin
                    soc <= 1'b0;
                    // last sample taken is the one present when eoc returns high
                    xs  <= x;
                    if (eoc) state <= S2;
                end
                S2: begin
                    for (int i = 0; i < C; i++)
                        if (ch == CW'(i)) avg[i] <= upd;
                    m     <= upd;
                    mch   <= ch;
                    z     <= 1'b1;
                    ch    <= (ch == CW'(C - 1)) ? '0 : ch + 1'b1;
                    state <= S0;
                end
                default: begin
                    state <= S0;
                    soc   <= 1'b0;
                    z     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ema_multicanale.sv
// Randomized scoreboard bench for ema_multicanale (N=8, K=2, C=4) with an ADC handshake model.
module tb_ema_multicanale;

    localparam int N  = 8;
    localparam int K  = 2;
    localparam int C  = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset_;
    logic          soc;
    logic          eoc;
    logic [N-1:0]  x;
    logic [CW-1:0] ch;
    logic [N-1:0]  m;
    logic [CW-1:0] mch;
    logic          z;

    ema_multicanale #(.N(N), .K(K), .C(C)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .eoc    (eoc),
        .x      (x),
        .ch     (ch),
        .m      (m),
        .mch    (mch),
        .z      (z)
    );

    always #5 clock = ~clock;

    typedef struct { int c; int mv; } exp_t;
    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: per-channel averages, advanced with plain integer arithmetic
    int ref_avg[C];
    bit ref_seeded[C];
    int conv_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int ema_ref(input int a, input int s);
        return (a * ((1 << K) - 1)) / (1 << K) + s / (1 << K);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < C; i++) begin
            ref_avg[i]    = 0;
            ref_seeded[i] = 1'b0;
        end
        conv_idx = 0;
        q.delete();
    endtask

    task automatic model_push(input int xv);
        exp_t e;
        int c;
        c = conv_idx % C;
`ifdef EMA_SEED_EN
        ref_avg[c]    = ref_seeded[c] ? ema_ref(ref_avg[c], xv) : xv;
        ref_seeded[c] = 1'b1;
`else
        ref_avg[c] = ema_ref(ref_avg[c], xv);
`endif
        e.c  = c;
        e.mv = ref_avg[c];
        q.push_back(e);
        conv_idx++;
    endtask

    // Monitor: every z pulse is matched against the oldest expected update
    logic prev_z = 1'b0;
    always @(negedge clock) begin
        if (reset_ && z) begin
            chk("z_width", int'(prev_z), 0);
            if (q.size() == 0) begin
                chk("z_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("m", int'(m), e.mv);
                chk("mch", int'(mch), e.c);
            end
        end
        prev_z = z;
    end

    // Wait for soc (bounded) and drive one conversion; called and returns at a negedge
    task automatic wait_soc(output bit ok);
        int t = 0;
        while (!soc && t < 20) begin
            @(negedge clock);
            t++;
        end
        ok = soc;
        if (!ok) chk("soc_timeout", 0, 1);
    endtask

    task automatic do_conv(input int xv, input int len);
        bit ok;
        int ec;
        wait_soc(ok);
        if (!ok) return;
        ec = conv_idx % C;
        chk("ch_sel", int'(ch), ec);
        @(posedge clock); #1 eoc = 1'b0; x = N'($urandom);
        @(posedge clock); #1;
        for (int i = 0; i < len; i++) begin
            @(posedge clock); #1 x = N'($urandom);
            @(negedge clock);
            chk("soc_low_busy", int'(soc), 0);
            chk("z_low_busy", int'(z), 0);
            chk("ch_stable", int'(ch), ec);
        end
        eoc = 1'b1;
        x   = N'(xv);
        model_push(xv);
        @(negedge clock);
        chk("z_not_early", int'(z), 0);
        @(negedge clock);
        chk("z_latency", int'(z), 1);
        chk("soc_low_at_z", int'(soc), 0);
        @(negedge clock);
        chk("soc_after_z", int'(soc), 1);
        chk("z_fall", int'(z), 0);
    endtask

    initial begin
        bit ok;
        reset_ = 1'b0;
        eoc    = 1'b1;
        x      = '0;
        model_clear();
        repeat (2) @(negedge clock);
        chk("rst_soc", int'(soc), 0);
        chk("rst_z", int'(z), 0);
        chk("rst_m", int'(m), 0);
        chk("rst_ch", int'(ch), 0);
        chk("rst_mch", int'(mch), 0);
        reset_ = 1'b1;

        // First round 10,20,30,40 then channel 0 again gives 17
        for (int i = 0; i < 5; i++) do_conv(40 * ((i % C) + 1), 1);

        // eoc held low for five clocks
        do_conv(77, 5);

        // Saturation: the average must settle without wrapping
        for (int i = 0; i < 40; i++) do_conv(255, 1);

        // Asynchronous reset in the middle of a conversion
        wait_soc(ok);
        @(posedge clock); #1 eoc = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_ = 1'b0;
        #1;
        chk("arst_soc", int'(soc), 0);
        chk("arst_z", int'(z), 0);
        chk("arst_m", int'(m), 0);
        chk("arst_ch", int'(ch), 0);
        chk("arst_mch", int'(mch), 0);
        eoc = 1'b1;
        model_clear();
        @(negedge clock);
        reset_ = 1'b1;

        // After reset: channel 0 with 100 twice gives 25 then 43
        for (int i = 0; i < 5; i++) do_conv(100, 1);

        for (int i = 0; i < 60; i++) do_conv(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)));

        repeat (4) @(negedge clock);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ema_multicanale.md
Name: ema_multicanale

Overview:
Parametrised successor of the single-channel exponential-average ADC reader. It round-robins over C ADC channels using the soc/eoc handshake and keeps one N-bit exponential moving average per channel, with weight alpha = 2^-K. After each conversion it publishes the updated average and its channel index with a one-cycle-wide z strobe. It sits between the ADC (plus its input mux) and downstream consumers.

Parameters:
N, 8, sample and average width in bits.
K, 2, weight shift; m_next = floor(m*(2^K-1)/2^K) + floor(x/2^K); valid range 1..N-1.
C, 4, number of channels; valid range 1..16; CW = max(1, clog2(C)).

Ports:
clock  in  1  system clock, posedge.
reset_  in  1  asynchronous, active-low reset.
soc  out  1  start of conversion to ADC.
eoc  in  1  end of conversion from ADC; 0 while converting, 1 when idle/done.
x  in  N  ADC sample; valid while eoc=1.
ch  out  CW  channel currently selected on the ADC input mux.
m  out  N  most recently updated average.
mch  out  CW  channel index that m belongs to.
z  out  1  high for exactly one clock when m/mch update.

Behaviour:
- Reset (reset_=0, async, dominates): soc=0, z=0, m=0, mch=0, ch=0, all C stored averages=0, state=S0. Reset mid-conversion aborts it; no update is emitted.
- S0: z<=0, soc<=1; eoc=0 -> S1, else stay in S0.
- S1: soc<=0; X<=x on every clock; eoc=1 -> S2, else stay in S1.
  - The captured sample is the x present at the edge where eoc is first seen at 1.
- S2:
  - avg[ch] <= f(avg[ch], X); m <= f(avg[ch], X); mch <= ch; z<=1.
  - ch <= (ch==C-1) ? 0 : ch+1; next state S0.
- ch is stable from S0 through S2 of a conversion. It changes only on the S2 exit edge, so the mux settles before the next soc.
- Latency: m/z update 1 clock after the edge where eoc=1 is captured. z falls on the following edge (S0).
- Arithmetic for f(a, s):
  - product p = a*(2^K-1) on N+K bits, no truncation; t = p>>K (N bits).
  - result = t + (s>>K), N bits. The sum is provably <= 2^N-1, so there is no overflow and no carry out.
  - Truncation toward zero; no rounding.
- C=1: ch and mch are held at 0; behaviour is identical to the single-channel block (N=8, K=2).
- A 2-bit state register holds S0/S1/S2. The encoding value 3 is unreachable; if entered, go to S0 with soc=0 and z=0.
- Only m, mch, z, soc and ch are registered outputs; no combinational input-to-output paths.

Optional Feature:
Macro EMA_SEED_EN.
- Defined: a per-channel valid bit is added, cleared by reset. On a channel's first S2 after reset, avg[ch] and m are set to X directly and the bit is set. Subsequent updates use f.
- Undefined: no valid bits; every update uses f starting from 0.

Decomposition:
- Shared package ema_pkg holds:
  - state localparams S0=0, S1=1, S2=2 and the state width 2;
  - the CW computation function (clog2 with minimum 1).
- One natural combinational sub-module, ema_step #(N, K): inputs a, s; output f(a, s). Built on the existing mul_add_nat and add library blocks; instantiated once and fed avg[ch] and X.

Test Plan:
1. Reset, then N=8, K=2, C=1: ADC model returns x=100 twice -> first z pulse m=25, second m=43 (75>>... i.e. 25*3=75, 75>>2=18, 18+25=43), mch=0 both times.
2. Saturation, N=8, K=2, C=1: preload by repeated x=255 until steady -> m reaches 252 and stays (252*3=756, 756>>2=189, 189+63=252). Never exceeds 255; no wrap.
3. C=4, x=4*(ch+1)*10 -> ch sequence 0,1,2,3,0; first-round m = 10, 20, 30, 40 with mch=0..3. Channel 0's second update uses stored 10: 7+10=17.
4. Handshake timing: eoc held 0 for 5 clocks -> soc=0 and no z throughout. Exactly one z pulse per eoc 0->1 cycle. soc rises on the edge after z's edge.
5. Assert reset_ in S1 mid-conversion -> soc, z, m, ch go 0 immediately (async). The next update uses avg=0.
6. With EMA_SEED_EN, C=2, x=200 then 100 then 200 -> m=200 (ch0 seed), 100 (ch1 seed), then ch0 m=150+50=200. Without the macro, the same stimulus gives 50, 25, 87.
